// File: rtl/ram_copy_master_if.sv
// Bus bundle for the single-cycle RAM protocol.
//   req    : one-cycle transaction request
//   we     : 1 = write, 0 = read
//   addr   : byte address, always word aligned
//   wdata  : write data
//   be     : byte enables
//   rdata  : read data returned with rvalid
//   rvalid : response strobe, one cycle after req (reads and writes)
interface ram_copy_master_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, rvalid
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, rvalid
  );
endinterface

// File: rtl/ram_copy_master.sv
// RAM copy/fill bus master.
// Copies len_i words from src_addr_i to dst_addr_i (mode_i=0), or writes
// pattern_i into len_i words starting at dst_addr_i (mode_i=1). One bus
// transaction outstanding at a time; each wait for rvalid is bounded by
// TIMEOUT_CYC cycles.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start_i, mode_i   start pulse (sampled in IDLE) and copy/fill select
//   src_addr_i        source byte address (copy only)
//   dst_addr_i        destination byte address
//   len_i             number of 32-bit words
//   pattern_i         fill word
//   busy_o, done_o    transfer active / one-cycle completion pulse
//   err_o             sticky error (misalignment or timeout)
//   words_done_o      words written and acknowledged
//   bus               RAM master port
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | waiting for start_i
// S_RD_REQ  | read request on the bus at src_ptr
// S_RD_WAIT | waiting for read data
// S_WR_REQ  | write request on the bus at dst_ptr
// S_WR_WAIT | waiting for write acknowledge
// S_DONE    | done_o pulse, back to idle
module ram_copy_master #(
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [31:0]      pattern_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] words_done_o,
  ram_copy_master_if.master bus
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      pat_q, pat_d;
  logic [31:0]      data_q, data_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [LEN_W-1:0] words_q, words_d;
  logic [LEN_W-1:0] words_inc;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;

  assign words_inc = words_q + LEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      data_q  <= '0;
      tmr_q   <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      data_q  <= data_d;
      tmr_q   <= tmr_d;
      words_q <= words_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    pat_d   = pat_q;
    data_d  = data_q;
    tmr_d   = tmr_q;
    words_d = words_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d  = mode_i;
          src_d   = src_addr_i;
          dst_d   = dst_addr_i;
          len_d   = len_i;
          pat_d   = pattern_i;
          err_d   = 1'b0;
          words_d = '0;
          // Source alignment only matters when the source is actually read.
          if ((!mode_i && src_addr_i[1:0] != 2'b00) || dst_addr_i[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (len_i == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = mode_i ? S_WR_REQ : S_RD_REQ;
          end
        end
      end
      S_RD_REQ: begin
        tmr_d   = TMR_LOAD;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (bus.rvalid) begin
          data_d  = bus.rdata;
          src_d   = src_q + 32'd4;
          state_d = S_WR_REQ;
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_WR_REQ: begin
        tmr_d   = TMR_LOAD;
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (bus.rvalid) begin
          dst_d   = dst_q + 32'd4;
          words_d = words_inc;
          if (words_inc == len_q) state_d = S_DONE;
          else                    state_d = mode_q ? S_WR_REQ : S_RD_REQ;
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe (req_o high exactly in the *_REQ cycle).
  always_comb begin
    req_d   = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
    we_d    = (state_d == S_WR_REQ);
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_d == S_RD_REQ) begin
      addr_d = src_d;
    end else if (state_d == S_WR_REQ) begin
      addr_d  = dst_d;
      wdata_d = mode_d ? pat_d : data_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign words_done_o = words_q;
  assign bus.req      = req_q;
  assign bus.we       = we_q;
  assign bus.addr     = addr_q;
  assign bus.wdata    = wdata_q;
  assign bus.be       = 4'hF;

endmodule

// File: tb/tb_ram_copy_master.sv
module tb_ram_copy_master;
  localparam int LEN_W = 16;
  localparam int TMO   = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start_i = 1'b0;
  logic             mode_i = 1'b0;
  logic [31:0]      src_addr_i = '0;
  logic [31:0]      dst_addr_i = '0;
  logic [LEN_W-1:0] len_i = '0;
  logic [31:0]      pattern_i = '0;
  logic             busy_o, done_o, err_o;
  logic [LEN_W-1:0] words_done_o;

  ram_copy_master_if bus ();

  ram_copy_master #(.LEN_W(LEN_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .pattern_i(pattern_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .words_done_o(words_done_o), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // RAM seen by the DUT and the reference model's own memory image.
  logic [31:0] ram     [int unsigned];
  logic [31:0] ref_mem [int unsigned];

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic seed_word(input logic [31:0] a, input logic [31:0] v);
    ram[a]     = v;
    ref_mem[a] = v;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t obs_q[$];
  txn_t exp_q[$];
  int   drop_read = -1;
  int   read_cnt  = 0;

  // Responder: answers every request one cycle later, except a read whose
  // index equals drop_read, which never gets rvalid.
  logic        rsp_r, rsp_w;
  logic [31:0] rsp_a, rsp_d;
  initial begin
    bus.rvalid = 1'b0;
    bus.rdata  = '0;
    forever begin
      @(posedge clk);
      rsp_r = bus.req;
      rsp_w = bus.we;
      rsp_a = bus.addr;
      rsp_d = bus.wdata;
      #1;
      bus.rvalid = 1'b0;
      if (rsp_r && rst_n) begin
        if (rsp_w) begin
          ram[rsp_a] = rsp_d;
          obs_q.push_back('{1'b1, rsp_a, rsp_d});
          bus.rvalid = 1'b1;
        end else begin
          obs_q.push_back('{1'b0, rsp_a, ram_rd(rsp_a)});
          if (read_cnt != drop_read) begin
            bus.rdata  = ram_rd(rsp_a);
            bus.rvalid = 1'b1;
          end
          read_cnt++;
        end
      end
    end
  end

  // Reference model: word-by-word transfer semantics, expected bus traffic,
  // result flags and cycles from the start edge to the done_o cycle.
  task automatic model(input logic mode, input logic [31:0] src, input logic [31:0] dst,
                       input int len, input logic [31:0] pat, input int drop,
                       output logic e_err, output int e_words, output int e_cyc);
    exp_q.delete();
    e_err   = 1'b0;
    e_words = 0;
    e_cyc   = 1;
    if ((!mode && src[1:0] != 2'b00) || dst[1:0] != 2'b00) begin
      e_err = 1'b1;
      return;
    end
    for (int i = 0; i < len; i++) begin
      logic [31:0] sa, da, dv;
      sa = src + 32'(4 * i);
      da = dst + 32'(4 * i);
      if (mode) begin
        dv = pat;
      end else begin
        dv = ref_rd(sa);
        exp_q.push_back('{1'b0, sa, dv});
        if (i == drop) begin
          e_err = 1'b1;
          e_cyc += 1 + TMO;
          return;
        end
        e_cyc += 2;
      end
      ref_mem[da] = dv;
      exp_q.push_back('{1'b1, da, dv});
      e_cyc += 2;
      e_words++;
    end
  endtask

  task automatic check_txns(input string name);
    int bad;
    bad = -1;
    check({name, "_txn_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (bad < 0 && (obs_q[i].we !== exp_q[i].we || obs_q[i].addr !== exp_q[i].addr ||
                      obs_q[i].data !== exp_q[i].data))
        bad = i;
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s_txn[%0d]: got we=%0b addr=0x%h data=0x%h expected we=%0b addr=0x%h data=0x%h",
               name, bad, obs_q[bad].we, obs_q[bad].addr, obs_q[bad].data,
               exp_q[bad].we, exp_q[bad].addr, exp_q[bad].data);
    end
    bad = -1;
    foreach (exp_q[i])
      if (bad < 0 && exp_q[i].we && ram_rd(exp_q[i].addr) !== ref_rd(exp_q[i].addr)) bad = i;
    check({name, "_mem_first_bad"}, 64'(bad), 64'(-1));
  endtask

  task automatic start_xfer(input logic mode, input logic [31:0] src, input logic [31:0] dst,
                            input int len, input logic [31:0] pat, input int drop);
    obs_q.delete();
    read_cnt  = 0;
    drop_read = drop;
    @(negedge clk);
    start_i    = 1'b1;
    mode_i     = mode;
    src_addr_i = src;
    dst_addr_i = dst;
    len_i      = LEN_W'(len);
    pattern_i  = pat;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  // Waits for done_o; returns cycle index of done (0 if never seen).
  task automatic wait_done(input string name, output int cyc, output logic g_err,
                           output int g_words, output int busy_cnt);
    cyc = 0; g_err = 1'b0; g_words = 0; busy_cnt = 0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
      if (done_o) begin
        cyc     = k;
        g_err   = err_o;
        g_words = int'(words_done_o);
        break;
      end
    end
    if (cyc == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_done_timeout: got no done_o expected done_o within 2000 cycles", name);
    end
  endtask

  task automatic run_and_check(input string name, input logic mode, input logic [31:0] src,
                               input logic [31:0] dst, input int len, input logic [31:0] pat,
                               input int drop, output logic g_err, output int g_words,
                               output int cyc);
    logic e_err;
    int   e_words, e_cyc, busy_cnt;
    model(mode, src, dst, len, pat, drop, e_err, e_words, e_cyc);
    start_xfer(mode, src, dst, len, pat, drop);
    wait_done(name, cyc, g_err, g_words, busy_cnt);
    check({name, "_cycles"}, 64'(cyc), 64'(e_cyc));
    check({name, "_err"}, 64'(g_err), 64'(e_err));
    check({name, "_words"}, 64'(g_words), 64'(e_words));
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(e_cyc - 1));
    check_txns(name);
    @(negedge clk);
    check({name, "_done_pulse"}, {62'd0, done_o, busy_o}, 64'd0);
    check({name, "_err_sticky"}, 64'(err_o), 64'(e_err));
  endtask

  typedef struct {
    string       name;
    logic        mode;
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    logic [31:0] pat;
    int          drop;
    logic        e_err;
    int          e_words;
    int          e_cyc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic g_err;
    int   g_words, cyc, busy_cnt;
    logic e_err;
    int   e_words, e_cyc;

    vecs[0] = '{"copy3",     1'b0, 32'h100, 32'h200,      3, 32'h0,        -1, 1'b0, 3, 13};
    vecs[1] = '{"fill4",     1'b1, 32'h0,   32'h40,       4, 32'hDEADBEEF, -1, 1'b0, 4, 9};
    vecs[2] = '{"len0",      1'b0, 32'h500, 32'h600,      0, 32'h0,        -1, 1'b0, 0, 1};
    vecs[3] = '{"dst_mis",   1'b1, 32'h0,   32'h202,      2, 32'h1,        -1, 1'b1, 0, 1};
    vecs[4] = '{"src_mis",   1'b0, 32'h101, 32'h700,      2, 32'h0,        -1, 1'b1, 0, 1};
    vecs[5] = '{"fill_srcx", 1'b1, 32'h103, 32'h800,      1, 32'h12345678, -1, 1'b0, 1, 3};
    vecs[6] = '{"timeout",   1'b0, 32'h300, 32'h400,      3, 32'h0,         1, 1'b1, 1, 22};
    vecs[7] = '{"wrap",      1'b1, 32'h0,   32'hFFFFFFFC, 2, 32'hA5A5A5A5, -1, 1'b0, 2, 5};

    seed_word(32'h100, 32'hAAAA0001);
    seed_word(32'h104, 32'hBBBB0002);
    seed_word(32'h108, 32'hCCCC0003);
    seed_word(32'h300, 32'h11110000);
    seed_word(32'h304, 32'h22220000);
    seed_word(32'h308, 32'h33330000);

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {60'd0, busy_o, done_o, err_o, bus.req}, 64'd0);
    check("reset_words", 64'(words_done_o), 64'd0);
    check("reset_bus", {bus.we, bus.addr, bus.wdata}, 64'd0);
    check("reset_be", 64'(bus.be), 64'hF);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      run_and_check(vecs[i].name, vecs[i].mode, vecs[i].src, vecs[i].dst, vecs[i].len,
                    vecs[i].pat, vecs[i].drop, g_err, g_words, cyc);
      check({vecs[i].name, "_tbl_err"}, 64'(g_err), 64'(vecs[i].e_err));
      check({vecs[i].name, "_tbl_words"}, 64'(g_words), 64'(vecs[i].e_words));
      check({vecs[i].name, "_tbl_cycles"}, 64'(cyc), 64'(vecs[i].e_cyc));
    end
    check("copy3_dst_word2", 64'(ram_rd(32'h208)), 64'hCCCC0003);
    check("wrap_word1", 64'(ram_rd(32'h0)), 64'hA5A5A5A5);

    // Start pulsed mid-run and a stray rvalid during a read request.
    model(1'b0, 32'h100, 32'h900, 3, 32'h0, -1, e_err, e_words, e_cyc);
    start_xfer(1'b0, 32'h100, 32'h900, 3, 32'h0, -1);
    cyc = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start_i = (k == 3);
      if (k == 3) begin
        src_addr_i = 32'hABC0;
        dst_addr_i = 32'hDEF0;
        len_i      = LEN_W'(1);
      end
      if (k == 5 && bus.req && !bus.we) bus.rvalid = 1'b1;
      if (done_o) begin
        cyc = k;
        break;
      end
    end
    start_i = 1'b0;
    check("ignore_cycles", 64'(cyc), 64'(e_cyc));
    check("ignore_words", 64'(words_done_o), 64'(e_words));
    check("ignore_err", 64'(err_o), 64'(e_err));
    check_txns("ignore");
    busy_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy_o || bus.req || done_o) busy_cnt++;
    end
    check("ignore_no_restart", 64'(busy_cnt), 64'd0);

    // Asynchronous reset in the middle of a copy.
    start_xfer(1'b0, 32'h300, 32'hA00, 3, 32'h0, -1);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req_busy", {62'd0, bus.req, busy_o}, 64'd0);
    check("rst_mid_words", 64'(words_done_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // After reset the ref image must follow the partial copy that landed.
    foreach (obs_q[i]) if (obs_q[i].we) ref_mem[obs_q[i].addr] = obs_q[i].data;
    repeat (2) @(negedge clk);
    check("rst_after_idle", {62'd0, busy_o, bus.req}, 64'd0);
    run_and_check("post_rst_fill", 1'b1, 32'h0, 32'hB00, 3, 32'h5A5A0F0F, -1, g_err, g_words, cyc);

    // Randomized transfers checked against the reference model.
    for (int t = 0; t < 24; t++) begin
      logic        mode;
      logic [31:0] src, dst, pat;
      int          len, drop;
      string       nm;
      mode = 1'($urandom_range(0, 1));
      len  = $urandom_range(0, 6);
      src  = 32'h1000 + 32'($urandom_range(0, 15) << 2);
      dst  = 32'h2000 + 32'($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 7) == 0) src = src + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) dst = dst + 32'($urandom_range(1, 3));
      pat  = $urandom;
      drop = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 6) : -1;
      for (int j = 0; j < 24; j++) seed_word(32'h1000 + 32'(4 * j), $urandom);
      nm = $sformatf("rnd%0d", t);
      run_and_check(nm, mode, src, dst, len, pat, drop, g_err, g_words, cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
